// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost thresholds, occupancy count
// and a choice of registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter bit          FWFT       = 1'b0,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must be in 1..FIFO_DEPTH");
  end
  if (AE_LEVEL >= FIFO_DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be below FIFO_DEPTH");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc, rd_acc;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_W'(AF_LEVEL));
  assign almostempty = (count_q != '0) && (count_q <= CNT_W'(AE_LEVEL));
  assign count       = count_q;

  // Acceptance is decided purely from pre-edge state, so a write into an empty FIFO is
  // never forwarded to a same-cycle read.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      data_out_d = mem[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_acc;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  // Storage is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    if (FWFT) begin
      data_out = empty ? '0 : mem[rd_ptr_q];
      rd_valid = !empty;
    end else begin
      data_out = data_out_q;
      rd_valid = rd_valid_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default registered-read FIFO (vector table),
// a depth-5 wrap-around run and a first-word-fall-through instance.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- default instance: depth 8, AF 7, AE 1, registered read ----
  logic        a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
  logic [15:0] a_din = '0, a_dout;
  logic        a_rv, a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;

  sync_fifo_param u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
    .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack), .overflow(a_ovf),
    .underflow(a_udf), .full(a_full), .empty(a_empty), .almostfull(a_af),
    .almostempty(a_ae), .count(a_cnt)
  );

  // ---- depth-5 instance ----
  logic        b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
  logic [15:0] b_din = '0, b_dout;
  logic        b_rv, b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_cnt;

  sync_fifo_param #(.FIFO_DEPTH(5)) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
    .data_out(b_dout), .rd_valid(b_rv), .wr_ack(b_ack), .overflow(b_ovf),
    .underflow(b_udf), .full(b_full), .empty(b_empty), .almostfull(b_af),
    .almostempty(b_ae), .count(b_cnt)
  );

  // ---- FWFT instance ----
  logic        c_rst = 1'b1, c_wr = 1'b0, c_rd = 1'b0;
  logic [15:0] c_din = '0, c_dout;
  logic        c_rv, c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
  logic [3:0]  c_cnt;

  sync_fifo_param #(.FWFT(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .wr_en(c_wr), .data_in(c_din), .rd_en(c_rd),
    .data_out(c_dout), .rd_valid(c_rv), .wr_ack(c_ack), .overflow(c_ovf),
    .underflow(c_udf), .full(c_full), .empty(c_empty), .almostfull(c_af),
    .almostempty(c_ae), .count(c_cnt)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    int          cnt;
    logic        ack;
    logic        ovf;
    logic        udf;
    logic        rv;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic rd, input logic [15:0] din, input int cnt,
                     input logic ack, input logic ovf, input logic udf, input logic rv,
                     input logic [15:0] dout);
    vec_t v;
    v = '{wr, rd, din, cnt, ack, ovf, udf, rv, dout};
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nw;
    int q[$];
    bit up;
    int exp_v;

    // Fill to full, overflow attempt.
    for (int i = 1; i <= 8; i++) add(1, 0, 16'(i), i, 1, 0, 0, 0, 16'h0000);
    add(1, 0, 16'h0009, 8, 0, 1, 0, 0, 16'h0000);
    // Drain in order, then underflow.
    for (int i = 1; i <= 8; i++) add(0, 1, 16'h0000, 8 - i, 0, 0, 0, 1, 16'(i));
    add(0, 1, 16'h0000, 0, 0, 0, 1, 0, 16'h0008);
    // Refill, then simultaneous read/write while full: read only.
    for (int i = 0; i < 8; i++) add(1, 0, 16'(16'h10 + i), i + 1, 1, 0, 0, 0, 16'h0008);
    add(1, 1, 16'h0099, 7, 0, 1, 0, 1, 16'h0010);
    for (int i = 1; i < 8; i++) add(0, 1, 16'h0000, 7 - i, 0, 0, 0, 1, 16'(16'h10 + i));
    // Simultaneous read/write while empty: write only.
    add(1, 1, 16'h0055, 1, 1, 0, 1, 0, 16'h0017);
    // Both accepted mid-range: count unchanged.
    add(1, 1, 16'h0066, 1, 1, 0, 0, 1, 16'h0055);
    add(0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'h0066);

    repeat (2) tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();

    chk("rst count", int'(a_cnt), 0);
    chk("rst empty", int'(a_empty), 1);
    chk("rst full", int'(a_full), 0);
    chk("rst ae", int'(a_ae), 0);
    chk("rst af", int'(a_af), 0);
    chk("rst rv", int'(a_rv), 0);
    chk("rst dout", int'(a_dout), 0);

    foreach (vecs[i]) begin
      a_wr  = vecs[i].wr;
      a_rd  = vecs[i].rd;
      a_din = vecs[i].din;
      tick();
      chk($sformatf("v%0d count", i), int'(a_cnt), vecs[i].cnt);
      chk($sformatf("v%0d full", i), int'(a_full), int'(vecs[i].cnt == 8));
      chk($sformatf("v%0d empty", i), int'(a_empty), int'(vecs[i].cnt == 0));
      chk($sformatf("v%0d af", i), int'(a_af), int'(vecs[i].cnt >= 7));
      chk($sformatf("v%0d ae", i), int'(a_ae), int'(vecs[i].cnt == 1));
      chk($sformatf("v%0d ack", i), int'(a_ack), int'(vecs[i].ack));
      chk($sformatf("v%0d ovf", i), int'(a_ovf), int'(vecs[i].ovf));
      chk($sformatf("v%0d udf", i), int'(a_udf), int'(vecs[i].udf));
      chk($sformatf("v%0d rv", i), int'(a_rv), int'(vecs[i].rv));
      chk($sformatf("v%0d dout", i), int'(a_dout), int'(vecs[i].dout));
    end
    a_wr = 1'b0; a_rd = 1'b0;
    tick();
    chk("idle ack", int'(a_ack), 0);
    chk("idle rv", int'(a_rv), 0);

    // Depth 5: oscillate occupancy between 2 and 5 so both pointers wrap.
    nw = 0;
    up = 1'b1;
    for (int cyc = 0; cyc < 80 && (nw < 12 || q.size() > 0); cyc++) begin
      bit do_w, do_r;
      if (q.size() == 5) up = 1'b0;
      if (q.size() <= 2 && nw < 12) up = 1'b1;
      do_w = up && nw < 12;
      do_r = !do_w && q.size() > 0;
      b_wr  = do_w;
      b_rd  = do_r;
      b_din = 16'(16'h0100 + nw);
      tick();
      if (do_w) begin
        q.push_back(16'h0100 + nw);
        nw++;
      end
      if (do_r) begin
        exp_v = q.pop_front();
        chk($sformatf("d5 c%0d dout", cyc), int'(b_dout), exp_v);
        chk($sformatf("d5 c%0d rv", cyc), int'(b_rv), 1);
      end
      chk($sformatf("d5 c%0d count", cyc), int'(b_cnt), q.size());
    end
    b_wr = 1'b0; b_rd = 1'b0;
    chk("d5 drained", q.size() + nw, 12);
    chk("d5 empty", int'(b_empty), 1);

    // FWFT: head word visible without rd_en.
    chk("fwft rst rv", int'(c_rv), 0);
    c_wr = 1'b1; c_din = 16'hABCD;
    tick();
    c_wr = 1'b0;
    chk("fwft dout", int'(c_dout), 16'hABCD);
    chk("fwft rv", int'(c_rv), 1);
    chk("fwft count", int'(c_cnt), 1);
    tick();
    chk("fwft hold", int'(c_dout), 16'hABCD);
    c_wr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      c_din = 16'(i);
      tick();
    end
    c_wr = 1'b0;
    chk("fwft head kept", int'(c_dout), 16'hABCD);
    c_rd = 1'b1;
    tick();
    c_rd = 1'b0;
    chk("fwft pop dout", int'(c_dout), 16'h0001);
    chk("fwft pop count", int'(c_cnt), 3);
    // Reset in the middle of a write burst discards everything.
    c_wr = 1'b1; c_din = 16'h00EE; c_rst = 1'b1;
    tick();
    c_rst = 1'b0; c_wr = 1'b0;
    chk("fwft rst count", int'(c_cnt), 0);
    chk("fwft rst empty", int'(c_empty), 1);
    chk("fwft rst rv", int'(c_rv), 0);
    chk("fwft rst ack", int'(c_ack), 0);
    c_wr = 1'b1; c_din = 16'h0077;
    tick();
    c_wr = 1'b0;
    chk("fwft post rst dout", int'(c_dout), 16'h0077);
    chk("fwft post rst count", int'(c_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
